// File: rtl/pll_reset_seq.sv
//------------------------------------------------------------------------------
// Module  : pll_reset_seq
// Brief   : Synchronises PLL lock, waits for stable lock, then sequences core reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pll_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    output logic       core_rst_n,
    output logic       lock_ok,
    output logic [7:0] lock_loss_count,
    output logic [1:0] state
);

    localparam int c_MAX_CYC = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_STAB_LAST = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT_LOCK  = 2'd0,
        S_STABILIZE  = 2'd1,
        S_HOLD_RESET = 2'd2,
        S_RUN        = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lock_ok;
    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_core_rst_n;
    logic [7:0]             r_loss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign w_lock_ok = r_sync[SYNC_STAGES-1];

    // core_rst_n is loaded with (next state == RUN); it defaults low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_WAIT_LOCK;
            r_cnt        <= '0;
            r_core_rst_n <= 1'b0;
            r_loss_cnt   <= '0;
        end else begin
            r_core_rst_n <= 1'b0;
            case (r_state)
                S_WAIT_LOCK: begin
                    r_cnt <= '0;
                    if (w_lock_ok) begin
                        r_state <= S_STABILIZE;
                    end
                end
                S_STABILIZE: begin
                    if (!w_lock_ok) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_STAB_LAST) begin
                        r_state <= S_HOLD_RESET;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_HOLD_RESET: begin
                    if (!w_lock_ok) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_HOLD_LAST) begin
                        r_state      <= S_RUN;
                        r_cnt        <= '0;
                        r_core_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_RUN: begin
                    r_cnt <= '0;
                    // Lock loss takes priority over a coincident software request.
                    if (!w_lock_ok) begin
                        r_state <= S_WAIT_LOCK;
                        if (r_loss_cnt != 8'hFF) begin
                            r_loss_cnt <= r_loss_cnt + 8'd1;
                        end
                    end else if (sw_reset_req) begin
                        r_state <= S_HOLD_RESET;
                    end else begin
                        r_core_rst_n <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_WAIT_LOCK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign core_rst_n      = r_core_rst_n;
    assign lock_ok         = w_lock_ok;
    assign lock_loss_count = r_loss_cnt;
    assign state           = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
//------------------------------------------------------------------------------
// Module  : tb_pll_reset_seq
// Brief   : Directed self-checking bench for pll_reset_seq (2/4/2 parameters).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pll_reset_seq;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       core_rst_n;
    logic       lock_ok;
    logic [7:0] lock_loss_count;
    logic [1:0] state;

    int vectors;
    int miscompares;

    pll_reset_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (4),
        .RESET_HOLD_CYCLES  (2)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .sw_reset_req    (sw_reset_req),
        .core_rst_n      (core_rst_n),
        .lock_ok         (lock_ok),
        .lock_loss_count (lock_loss_count),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Inputs change and outputs are sampled on falling edges; after step(k)
    // from the set-up negedge, the bench observes the state after edge N+k-1.
    task automatic lock_and_check(input string tag);
        pll_locked = 1'b1;
        step(2);  chk({tag, "_lockok_N+1"}, lock_ok, 1);
                  chk({tag, "_state_N+1"},  state,   0);
        step(1);  chk({tag, "_state_N+2"},  state,   1);
        step(3);  chk({tag, "_state_N+5"},  state,   1);
        step(1);  chk({tag, "_state_N+6"},  state,   2);
        step(1);  chk({tag, "_core_N+7"},   core_rst_n, 0);
        step(1);  chk({tag, "_state_N+8"},  state,   3);
                  chk({tag, "_core_N+8"},   core_rst_n, 1);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;

        // Power-up reset
        step(3);
        chk("rst_state", state, 0);
        chk("rst_core", core_rst_n, 0);
        chk("rst_lockok", lock_ok, 0);
        chk("rst_loss", lock_loss_count, 0);
        rst_n = 1'b1;
        step(2);
        chk("idle_state", state, 0);

        lock_and_check("pwrup");
        step(3);
        chk("run_hold", state, 3);

        // Software reset in RUN: core reset low for exactly two cycles
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        chk("sw_state_E", state, 2);
        chk("sw_core_E", core_rst_n, 0);
        step(1);
        chk("sw_core_E+1", core_rst_n, 0);
        step(1);
        chk("sw_core_E+2", core_rst_n, 1);
        chk("sw_state_E+2", state, 3);
        chk("sw_loss", lock_loss_count, 0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        step(2);
        chk("loss_core_M+1", core_rst_n, 1);
        step(1);
        chk("loss_state_M+2", state, 0);
        chk("loss_core_M+2", core_rst_n, 0);
        chk("loss_cnt", lock_loss_count, 1);
        lock_and_check("relock");

        // Lock loss coincident with software request
        pll_locked = 1'b0;
        step(2);
        sw_reset_req = 1'b1;
        step(1);
        chk("simul_state", state, 0);
        chk("simul_cnt", lock_loss_count, 2);
        step(2);
        chk("sw_ignored_wait", state, 0);
        sw_reset_req = 1'b0;

        // Drive the loss counter into saturation
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            step(9);
            pll_locked = 1'b0;
            step(3);
            if (i == 251) chk("sat_254", lock_loss_count, 254);
            if (i == 252) chk("sat_255", lock_loss_count, 255);
        end
        chk("sat_hold", lock_loss_count, 255);

        // Asynchronous reset mid-cycle while in RUN
        pll_locked = 1'b1;
        step(9);
        chk("pre_async_state", state, 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        pll_locked = 1'b0;
        #1;
        chk("async_core", core_rst_n, 0);
        chk("async_state", state, 0);
        chk("async_lockok", lock_ok, 0);
        chk("async_loss", lock_loss_count, 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Glitchy lock: 3 cycles high, 1 low, then high
        pll_locked = 1'b1;
        step(3);
        chk("glitch_state_N+2", state, 1);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        chk("glitch_state_N+5", state, 0);
        step(1);
        chk("glitch_state_N+6", state, 1);
        chk("glitch_core", core_rst_n, 0);
        chk("glitch_loss", lock_loss_count, 0);
        step(4);
        chk("glitch_state_N+10", state, 2);
        step(2);
        chk("glitch_run", state, 3);
        chk("glitch_run_core", core_rst_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
